// File: rtl/cpu_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32 (low word) multiply cell between NUM_REQ requesters.
// Optional statistics counters are built when CPU_MULT_ARB_STATS_EN is defined.
module cpu_mult_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = 2,
   parameter int CELL_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [32*NUM_REQ-1:0]   req_src1,
   input  logic [32*NUM_REQ-1:0]   req_src2,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [31:0]             mul_src1,
   output logic [31:0]             mul_src2,
   input  logic [31:0]             mul_result,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [31:0]             rsp_result,
   output logic                    busy
`ifdef CPU_MULT_ARB_STATS_EN
   ,
   output logic [31:0]             stat_issue_cnt,
   output logic [31:0]             stat_conflict_cnt
`endif
);

   logic [ID_W-1:0]         rr_ptr_r;
   logic [ID_W-1:0]         rr_ptr_next_s;
   logic [NUM_REQ-1:0]      grant_s;
   logic [ID_W-1:0]         grant_id_s;
   logic [31:0]             sel_src1_s;
   logic [31:0]             sel_src2_s;
   logic                    found_s;
   logic                    accept_s;
   logic [CELL_LATENCY-1:0] tag_vld_r;
   logic [ID_W-1:0]         tag_id_r [CELL_LATENCY];
   logic [NUM_REQ-1:0]      rsp_next_s;

   // Round-robin scan: pass 0 covers rr_ptr..NUM_REQ-1, pass 1 wraps to 0..rr_ptr-1.
   always_comb begin
      grant_s       = '0;
      grant_id_s    = '0;
      sel_src1_s    = 32'h0000_0000;
      sel_src2_s    = 32'h0000_0000;
      rr_ptr_next_s = rr_ptr_r;
      found_s       = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found_s && req_valid[j] && ((pass == 0) == (j >= int'(rr_ptr_r)))) begin
               found_s       = 1'b1;
               grant_s[j]    = 1'b1;
               grant_id_s    = ID_W'(j);
               sel_src1_s    = req_src1[32*j +: 32];
               sel_src2_s    = req_src2[32*j +: 32];
               rr_ptr_next_s = (j == NUM_REQ - 1) ? '0 : ID_W'(j + 1);
            end else begin
               found_s = found_s;
            end
         end
      end
   end

   assign req_ready = (reset || flush) ? '0 : grant_s;
   assign accept_s  = |req_ready;

   // Decode the last tag stage into the one-hot response vector.
   always_comb begin
      rsp_next_s = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         rsp_next_s[j] = tag_vld_r[CELL_LATENCY-1] && (tag_id_r[CELL_LATENCY-1] == ID_W'(j));
      end
   end

   // Operand registers, round-robin pointer, tag pipeline and response register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_r  <= '0;
         mul_src1  <= 32'h0000_0000;
         mul_src2  <= 32'h0000_0000;
         tag_vld_r <= '0;
         for (int k = 0; k < CELL_LATENCY; k++) begin
            tag_id_r[k] <= '0;
         end
         rsp_valid <= '0;
      end else if (flush) begin
         // Results already in the cell are orphaned; only the owner tags need killing.
         tag_vld_r <= '0;
         rsp_valid <= '0;
      end else begin
         if (accept_s) begin
            rr_ptr_r <= rr_ptr_next_s;
            mul_src1 <= sel_src1_s;
            mul_src2 <= sel_src2_s;
         end
         tag_vld_r[0] <= accept_s;
         tag_id_r[0]  <= grant_id_s;
         for (int k = 1; k < CELL_LATENCY; k++) begin
            tag_vld_r[k] <= tag_vld_r[k-1];
            tag_id_r[k]  <= tag_id_r[k-1];
         end
         rsp_valid <= rsp_next_s;
      end
   end

   assign rsp_result = mul_result;
   assign busy       = |tag_vld_r;

`ifdef CPU_MULT_ARB_STATS_EN
   logic multi_req_s;
   assign multi_req_s = (req_valid & (req_valid - NUM_REQ'(1))) != '0;

   // Issue and contention counters; both wrap naturally and ignore flush for issue counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_issue_cnt    <= 32'h0000_0000;
         stat_conflict_cnt <= 32'h0000_0000;
      end else begin
         if (accept_s) begin
            stat_issue_cnt <= stat_issue_cnt + 32'd1;
         end
         if (multi_req_s && !flush) begin
            stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
         end
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cpu_mult_arbiter.sv
// Scoreboard bench for cpu_mult_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares whenever rsp_valid is presented.
module tb_cpu_mult_arbiter;

   localparam int N  = 4;
   localparam int CL = 1;

   logic            clk;
   logic            reset;
   logic            flush;
   logic [N-1:0]    req_valid;
   logic [32*N-1:0] req_src1;
   logic [32*N-1:0] req_src2;
   logic [N-1:0]    req_ready;
   logic [31:0]     mul_src1;
   logic [31:0]     mul_src2;
   logic [31:0]     mul_result;
   logic [N-1:0]    rsp_valid;
   logic [31:0]     rsp_result;
   logic            busy;
`ifdef CPU_MULT_ARB_STATS_EN
   logic [31:0]     stat_issue_cnt;
   logic [31:0]     stat_conflict_cnt;
   int              exp_issue;
   int              exp_conflict;
`endif

   cpu_mult_arbiter #(.NUM_REQ(N), .ID_W(2), .CELL_LATENCY(CL)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_src1   (req_src1),
      .req_src2   (req_src2),
      .req_ready  (req_ready),
      .mul_src1   (mul_src1),
      .mul_src2   (mul_src2),
      .mul_result (mul_result),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .busy       (busy)
`ifdef CPU_MULT_ARB_STATS_EN
      ,
      .stat_issue_cnt    (stat_issue_cnt),
      .stat_conflict_cnt (stat_conflict_cnt)
`endif
   );

   typedef struct {
      int          due;
      int          id;
      logic [31:0] res;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic [31:0] op_a [N];
   logic [31:0] op_b [N];
   logic [31:0] cell_pipe [CL];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Multiply cell model: result valid CL edges after the operands change.
   always @(posedge clk) begin
      cell_pipe[0] <= mul_src1 * mul_src2;
      for (int k = 1; k < CL; k++) cell_pipe[k] <= cell_pipe[k-1];
   end
   assign mul_result = cell_pipe[CL-1];

   always_comb begin
      req_src1 = '0;
      req_src2 = '0;
      for (int i = 0; i < N; i++) begin
         req_src1[32*i +: 32] = op_a[i];
         req_src2[32*i +: 32] = op_b[i];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] prod(input int i);
      logic [31:0] p;
      p = op_a[i] * op_b[i];
      return p;
   endfunction

   // Monitor: flag overdue entries, then compare any presented response against the queue head.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
         checks++;
         failures++;
         $display("FAIL missing_rsp id=%0d due=%0d now=%0d", sb[0].id, sb[0].due, cyc);
         void'(sb.pop_front());
      end
      if (rsp_valid != '0) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp rsp_valid=%b result=0x%08h cycle=%0d", rsp_valid, rsp_result, cyc);
         end else begin
            exp_t e;
            logic [N-1:0] oh;
            e  = sb.pop_front();
            oh = '0;
            oh[e.id] = 1'b1;
            check("rsp_cycle", 32'(cyc), 32'(e.due));
            check("rsp_valid", 32'(rsp_valid), 32'(oh));
            check("rsp_result", rsp_result, e.res);
         end
      end
   end

   // One cycle of stimulus with expected grant and busy; optionally schedule the response.
   task automatic step(input logic [N-1:0] vld, input logic [N-1:0] exp_rdy,
                       input logic exp_busy, input logic push, input logic [31:0] exp_res);
      req_valid = vld;
      @(negedge clk);
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(exp_busy));
      if (push && exp_rdy != '0) begin
         exp_t e;
         e.due = cyc + 1 + CL;
         e.res = exp_res;
         e.id  = 0;
         for (int i = 0; i < N; i++) if (exp_rdy[i]) e.id = i;
         sb.push_back(e);
      end
`ifdef CPU_MULT_ARB_STATS_EN
      if (!reset && !flush) begin
         if (exp_rdy != '0) exp_issue++;
         if ($countones(vld) >= 2) exp_conflict++;
      end
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      req_valid = '0;
      for (int i = 0; i < N; i++) begin
         op_a[i] = 32'h0000_0100 * (i + 1) + 32'd7;
         op_b[i] = 32'h0000_0003 + 32'(i);
      end
`ifdef CPU_MULT_ARB_STATS_EN
      exp_issue    = 0;
      exp_conflict = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      // Reset state: no grant even with every request up.
      step(4'hF, 4'h0, 1'b0, 1'b0, 32'h0);
      check("mul_src1_rst", mul_src1, 32'h0000_0000);
      check("mul_src2_rst", mul_src2, 32'h0000_0000);
      reset = 1'b0;

      // Fairness: all valid for 8 cycles.
      step(4'hF, 4'h1, 1'b0, 1'b1, prod(0));
      step(4'hF, 4'h2, 1'b1, 1'b1, prod(1));
      step(4'hF, 4'h4, 1'b1, 1'b1, prod(2));
      step(4'hF, 4'h8, 1'b1, 1'b1, prod(3));
      step(4'hF, 4'h1, 1'b1, 1'b1, prod(0));
      step(4'hF, 4'h2, 1'b1, 1'b1, prod(1));
      step(4'hF, 4'h4, 1'b1, 1'b1, prod(2));
      step(4'hF, 4'h8, 1'b1, 1'b1, prod(3));
      step(4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      step(4'h0, 4'h0, 1'b0, 1'b0, 32'h0);

      // Basic multiply from requester 0.
      op_a[0] = 32'h0001_0003;
      op_b[0] = 32'h0000_0005;
      step(4'h1, 4'h1, 1'b0, 1'b1, 32'h0005_000F);
      step(4'h0, 4'h0, 1'b1, 1'b0, 32'h0);

      // Overflow cases on requester 2, back to back.
      op_a[2] = 32'hFFFF_FFFF;
      op_b[2] = 32'hFFFF_FFFF;
      step(4'h4, 4'h4, 1'b0, 1'b1, 32'h0000_0001);
      op_a[2] = 32'h8000_0000;
      op_b[2] = 32'h0000_0002;
      step(4'h4, 4'h4, 1'b1, 1'b1, 32'h0000_0000);
      step(4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      check("mul_src1_hold", mul_src1, 32'h8000_0000);

      // Flush kills the in-flight op from requester 1 and blocks grants; pointer holds at 2.
      step(4'h2, 4'h2, 1'b0, 1'b0, 32'h0);
      flush = 1'b1;
      step(4'hF, 4'h0, 1'b1, 1'b0, 32'h0);
      flush = 1'b0;
      step(4'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      step(4'hF, 4'h4, 1'b0, 1'b1, prod(2));
      step(4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      step(4'h0, 4'h0, 1'b0, 1'b0, 32'h0);

      // Reset with two ops in flight: both are lost, next grant goes to requester 0.
      step(4'hF, 4'h8, 1'b0, 1'b0, 32'h0);
      step(4'hF, 4'h1, 1'b1, 1'b0, 32'h0);
      reset = 1'b1;
`ifdef CPU_MULT_ARB_STATS_EN
      exp_issue    = 0;
      exp_conflict = 0;
`endif
      step(4'hF, 4'h0, 1'b0, 1'b0, 32'h0);
      step(4'hF, 4'h0, 1'b0, 1'b0, 32'h0);
      reset = 1'b0;
      step(4'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      step(4'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      step(4'hF, 4'h1, 1'b0, 1'b1, prod(0));
      step(4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      repeat (4) step(4'h0, 4'h0, 1'b0, 1'b0, 32'h0);

      check("sb_drained", 32'(sb.size()), 32'd0);
`ifdef CPU_MULT_ARB_STATS_EN
      check("stat_issue", stat_issue_cnt, 32'(exp_issue));
      check("stat_conflict", stat_conflict_cnt, 32'(exp_conflict));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
